// File: rtl/lcd_sed_controller.sv
// rtl/lcd_sed_controller.sv - SED1565-class LCD controller with display RAM and per-pixel scan-out
//
// Decodes CPU command/data accesses at two bus addresses, owns the page/column
// display RAM, and exposes a pipelined per-pixel scan-out port.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset (honoured on clk_ce cycles)
//   clk_ce          bus-side clock enable
//   bus_write       write strobe (rising edge fires an access)
//   bus_read        read strobe (rising edge fires an access when no write fires)
//   address_in      bus address (CMD_ADDR = command/status, DATA_ADDR = display data)
//   data_in         write data
//   data_out        read data, combinational
//   lcd_contrast    effective contrast
//   scan_x, scan_y  scan pixel coordinate
//   scan_pixel      pixel value, two clk after scan_x/scan_y

module lcd_sed_controller #(
    parameter int          COLS      = 132,
    parameter int          PAGES     = 9,
    parameter int          LINES     = 64,
    parameter logic [23:0] CMD_ADDR  = 24'h20FE,
    parameter logic [23:0] DATA_ADDR = 24'h20FF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_ce,
    input  logic                     bus_write,
    input  logic                     bus_read,
    input  logic [23:0]              address_in,
    input  logic [7:0]               data_in,
    output logic [7:0]               data_out,
    output logic [5:0]               lcd_contrast,
    input  logic [7:0]               scan_x,
    input  logic [$clog2(LINES)-1:0] scan_y,
    output logic                     scan_pixel
);

    localparam int LW    = $clog2(LINES);
    localparam int DEPTH = PAGES * COLS;
    localparam int AW    = $clog2(DEPTH);

    // Bus-side state
    logic          r_bus_write_q;
    logic          r_bus_read_q;
    logic [5:0]    r_contrast;
    logic          r_contrast_pending;
    logic [7:0]    r_column;
    logic [3:0]    r_page;
    logic [LW-1:0] r_start_line;
    logic          r_seg_dir;
    logic          r_max_contrast;
    logic          r_all_on;
    logic          r_invert;
    logic          r_display_on;
    logic          r_row_order;
    logic          r_rmw;
    logic [7:0]    r_rmw_col;
    logic [7:0]    r_rd_buf;

    // Display RAM, page-major: index = page*COLS + column
    logic [7:0]    r_ram [0:DEPTH-1];
    logic [7:0]    r_prefetch;

    // Scan pipeline
    logic [7:0]    r_scan_byte;
    logic [2:0]    r_scan_bit_sel;
    logic          r_scan_ok;
    logic          r_scan_pixel;

    logic          w_is_cmd;
    logic          w_is_data;
    logic          w_wr_edge;
    logic          w_rd_edge;
    logic          w_pend_wr;
    logic          w_cmd_wr;
    logic          w_data_wr;
    logic          w_soft_reset;
    logic [7:0]    w_phys_col;
    logic          w_bus_ok;
    logic [AW-1:0] w_bus_idx;
    logic [7:0]    w_col_next;
    logic [7:0]    w_rd_value;
    logic [LW-1:0] w_l;
    logic [LW-1:0] w_line;
    logic          w_scan_ok;
    logic [AW-1:0] w_scan_idx;

    assign w_is_cmd  = (address_in == CMD_ADDR);
    assign w_is_data = (address_in == DATA_ADDR);

    // Edge detect against the strobe copies taken on the previous clk_ce cycle
    assign w_wr_edge = clk_ce && bus_write && !r_bus_write_q;
    assign w_rd_edge = clk_ce && bus_read && !r_bus_read_q && !w_wr_edge;

    // A pending contrast value swallows the next write to either address
    assign w_pend_wr    = w_wr_edge && (w_is_cmd || w_is_data) && r_contrast_pending;
    assign w_cmd_wr     = w_wr_edge && w_is_cmd && !r_contrast_pending;
    assign w_data_wr    = w_wr_edge && w_is_data && !r_contrast_pending;
    assign w_soft_reset = w_cmd_wr && (data_in == 8'hE2);

    assign w_phys_col = r_seg_dir ? (8'(COLS - 1) - r_column) : r_column;
    assign w_bus_ok   = (int'(r_page) < PAGES) && (int'(r_column) < COLS)
                        && (int'(w_phys_col) < COLS);
    assign w_bus_idx  = AW'(int'(r_page) * COLS + int'(w_phys_col));
    assign w_col_next = (int'(r_column) < COLS - 1) ? (r_column + 8'd1) : r_column;

    // The last page is only one pixel high; its upper bits read back as zero
    assign w_rd_value = !w_bus_ok                     ? 8'h00 :
                        (int'(r_page) == PAGES - 1)   ? {7'b0, r_prefetch[0]} :
                                                        r_prefetch;

    always_ff @(posedge clk) begin
        if (clk_ce) begin
            r_bus_write_q <= bus_write;
            r_bus_read_q  <= bus_read;
            if (reset || w_soft_reset) begin
                r_contrast         <= 6'h20;
                r_contrast_pending <= 1'b0;
                r_column           <= 8'd0;
                r_page             <= 4'd0;
                r_start_line       <= '0;
                r_seg_dir          <= 1'b0;
                r_max_contrast     <= 1'b0;
                r_all_on           <= 1'b0;
                r_invert           <= 1'b0;
                r_display_on       <= 1'b0;
                r_row_order        <= 1'b0;
                r_rmw              <= 1'b0;
                r_rmw_col          <= 8'd0;
            end else if (w_pend_wr) begin
                r_contrast         <= data_in[5:0];
                r_contrast_pending <= 1'b0;
            end else if (w_cmd_wr) begin
                casez (data_in)
                    8'b0000_????: r_column[3:0]      <= data_in[3:0];
                    8'b0001_????: r_column[7:4]      <= data_in[3:0];
                    8'b01??_????: r_start_line       <= LW'(data_in[5:0]);
                    8'b1000_0001: r_contrast_pending <= 1'b1;
                    8'b1010_000?: r_seg_dir          <= data_in[0];
                    8'b1010_001?: r_max_contrast     <= data_in[0];
                    8'b1010_010?: r_all_on           <= data_in[0];
                    8'b1010_011?: r_invert           <= data_in[0];
                    8'b1010_111?: r_display_on       <= data_in[0];
                    8'b1011_????: r_page             <= data_in[3:0];
                    8'b1100_????: r_row_order        <= data_in[3];
                    8'b1110_0000: begin
                        r_rmw     <= 1'b1;
                        r_rmw_col <= r_column;
                    end
                    8'b1110_1110: begin
                        r_rmw    <= 1'b0;
                        r_column <= r_rmw_col;
                    end
                    default: ;
                endcase
            end else if (w_data_wr) begin
                r_column <= w_col_next;
            end else if (w_rd_edge && w_is_data) begin
                r_rd_buf <= w_rd_value;
                if (!r_rmw) begin
                    r_column <= w_col_next;
                end
            end else if (w_rd_edge && w_is_cmd && r_contrast_pending) begin
                r_contrast         <= 6'h3F;
                r_contrast_pending <= 1'b0;
            end
            if (reset) begin
                r_rd_buf <= 8'h00;
            end
        end
    end

    // Bus write port and bus prefetch port; prefetch follows (page, phys_col)
    // every clk so a read strobe sees data at most one clk old.
    always_ff @(posedge clk) begin
        if (w_data_wr && w_bus_ok && !reset) begin
            r_ram[w_bus_idx] <= data_in;
        end
        r_prefetch <= r_ram[w_bus_ok ? w_bus_idx : '0];
    end

    // Scan stage 1: line mapping and RAM fetch
    assign w_l        = r_row_order ? (LW'(LINES - 1) - scan_y) : scan_y;
    assign w_line     = w_l + r_start_line;
    assign w_scan_ok  = int'(scan_x) < COLS;
    assign w_scan_idx = AW'(int'(w_line >> 3) * COLS + int'(scan_x));

    always_ff @(posedge clk) begin
        r_scan_byte    <= r_ram[w_scan_ok ? w_scan_idx : '0];
        r_scan_bit_sel <= w_line[2:0];
        r_scan_ok      <= w_scan_ok;
    end

    // Scan stage 2: bit select and display modes
    always_ff @(posedge clk) begin
        if (!r_display_on) begin
            r_scan_pixel <= 1'b0;
        end else if (r_all_on) begin
            r_scan_pixel <= 1'b1;
        end else begin
            r_scan_pixel <= (r_scan_ok && r_scan_byte[r_scan_bit_sel]) ^ r_invert;
        end
    end

    assign scan_pixel   = r_scan_pixel;
    assign lcd_contrast = r_max_contrast ? 6'h3F : r_contrast;

    always_comb begin
        data_out = 8'h00;
        if (!r_contrast_pending) begin
            if (w_is_cmd) begin
                data_out = 8'h40 | {2'b00, r_display_on, 5'b00000};
            end else if (w_is_data) begin
                data_out = r_rd_buf;
            end
        end
    end

endmodule
